// File: rtl/register_bank_if.sv
// Bus bundle for register_bank: two combinational read ports, one formatted
// write port, a clear request and the ready status.
interface register_bank_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5
);
    logic [AW-1:0]   rd_address_a;
    logic [AW-1:0]   rd_address_b;
    logic [XLEN-1:0] data_out_a;
    logic [XLEN-1:0] data_out_b;
    logic            wr_enable;
    logic [AW-1:0]   wr_address;
    logic [XLEN-1:0] wr_data;
    logic [2:0]      write_pattern;
    logic            clear_req;
    logic            ready;

    // Handshake: a write is taken at a rising edge only while ready is high;
    // there is no backpressure beyond ready, and nothing is held for later.
    modport master (
        output rd_address_a, rd_address_b, wr_enable, wr_address, wr_data,
               write_pattern, clear_req,
        input  data_out_a, data_out_b, ready
    );

    modport slave (
        input  rd_address_a, rd_address_b, wr_enable, wr_address, wr_data,
               write_pattern, clear_req,
        output data_out_a, data_out_b, ready
    );
endinterface

// File: rtl/register_bank.sv
// Register file with load-style write formatting, x0 hardwired to zero,
// optional write-to-read bypass and a sequential clear sweep.
module register_bank #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst_n,
    register_bank_if.slave  bus,
    output logic            state_o
);
    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic            ready_q;
    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] fmt_data;
    logic            fmt_legal;
    logic            wr_commit;

    assign state_o   = state_q;
    assign bus.ready = ready_q;

    always_comb begin
        fmt_data  = '0;
        fmt_legal = 1'b1;
        unique case (bus.write_pattern)
            3'b000: begin
                fmt_data      = {XLEN{bus.wr_data[7]}};
                fmt_data[7:0] = bus.wr_data[7:0];
            end
            3'b001: begin
                fmt_data       = {XLEN{bus.wr_data[15]}};
                fmt_data[15:0] = bus.wr_data[15:0];
            end
            3'b010: begin
                fmt_data       = {XLEN{bus.wr_data[31]}};
                fmt_data[31:0] = bus.wr_data[31:0];
            end
            3'b011: begin
                fmt_data  = bus.wr_data;
                fmt_legal = (XLEN == 64);
            end
            3'b100: fmt_data[7:0]  = bus.wr_data[7:0];
            3'b101: fmt_data[15:0] = bus.wr_data[15:0];
            3'b110: begin
                fmt_data[31:0] = bus.wr_data[31:0];
                fmt_legal      = (XLEN == 64);
            end
            default: fmt_legal = 1'b0;
        endcase
    end

    assign wr_commit = ready_q && bus.wr_enable && (bus.wr_address != '0)
                       && fmt_legal && !bus.clear_req;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_READY: begin
                if (bus.clear_req) begin
                    state_d = ST_CLEAR;
                    cnt_d   = AW'(1);
                end
            end
            default: begin
                if (bus.clear_req) begin
                    cnt_d = AW'(1);
                end else if (cnt_q == AW'(NREGS - 1)) begin
                    // Leave before the increment so the counter never wraps.
                    state_d = ST_READY;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_CLEAR;
            cnt_q   <= AW'(1);
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= (state_d == ST_READY);
        end
    end

    // The array has no reset; the sweep zeroes it once rst_n is released.
    always_ff @(posedge clk) begin
        if (state_q == ST_CLEAR) begin
            regs_q[cnt_q] <= '0;
        end else if (wr_commit) begin
            regs_q[bus.wr_address] <= fmt_data;
        end
    end

    always_comb begin
        bus.data_out_a = '0;
        if (ready_q && bus.rd_address_a != '0) begin
            if (BYPASS != 0 && wr_commit && bus.rd_address_a == bus.wr_address) begin
                bus.data_out_a = fmt_data;
            end else begin
                bus.data_out_a = regs_q[bus.rd_address_a];
            end
        end
    end

    always_comb begin
        bus.data_out_b = '0;
        if (ready_q && bus.rd_address_b != '0) begin
            if (BYPASS != 0 && wr_commit && bus.rd_address_b == bus.wr_address) begin
                bus.data_out_b = fmt_data;
            end else begin
                bus.data_out_b = regs_q[bus.rd_address_b];
            end
        end
    end
endmodule

// File: tb/tb_register_bank.sv
// Directed bench driving three register_bank variants (bypass, no bypass,
// 64-bit) with the same stimulus and hand-computed expectations.
module tb_register_bank;
    logic        clk;
    logic        rst_n;
    logic [4:0]  rd_a, rd_b, wa;
    logic        we, clr;
    logic [63:0] wd;
    logic [2:0]  pat;
    logic        st_byp, st_nob, st_x64;
    int          n_tests;
    int          n_fail;

    register_bank_if #(.XLEN(32), .AW(5)) bus_byp ();
    register_bank_if #(.XLEN(32), .AW(5)) bus_nob ();
    register_bank_if #(.XLEN(64), .AW(5)) bus_x64 ();

    assign bus_byp.rd_address_a = rd_a;
    assign bus_byp.rd_address_b = rd_b;
    assign bus_byp.wr_enable = we;
    assign bus_byp.wr_address = wa;
    assign bus_byp.wr_data = wd[31:0];
    assign bus_byp.write_pattern = pat;
    assign bus_byp.clear_req = clr;

    assign bus_nob.rd_address_a = rd_a;
    assign bus_nob.rd_address_b = rd_b;
    assign bus_nob.wr_enable = we;
    assign bus_nob.wr_address = wa;
    assign bus_nob.wr_data = wd[31:0];
    assign bus_nob.write_pattern = pat;
    assign bus_nob.clear_req = clr;

    assign bus_x64.rd_address_a = rd_a;
    assign bus_x64.rd_address_b = rd_b;
    assign bus_x64.wr_enable = we;
    assign bus_x64.wr_address = wa;
    assign bus_x64.wr_data = wd;
    assign bus_x64.write_pattern = pat;
    assign bus_x64.clear_req = clr;

    register_bank #(.XLEN(32), .NREGS(32), .BYPASS(1)) dut_byp (
        .clk(clk), .rst_n(rst_n), .bus(bus_byp), .state_o(st_byp));
    register_bank #(.XLEN(32), .NREGS(32), .BYPASS(0)) dut_nob (
        .clk(clk), .rst_n(rst_n), .bus(bus_nob), .state_o(st_nob));
    register_bank #(.XLEN(64), .NREGS(32), .BYPASS(1)) dut_x64 (
        .clk(clk), .rst_n(rst_n), .bus(bus_x64), .state_o(st_x64));

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_ready(input string tag, input logic exp);
        check({tag, "_byp"}, {63'd0, bus_byp.ready}, {63'd0, exp});
        check({tag, "_nob"}, {63'd0, bus_nob.ready}, {63'd0, exp});
        check({tag, "_x64"}, {63'd0, bus_x64.ready}, {63'd0, exp});
        check({tag, "_st"},  {63'd0, st_byp}, {63'd0, exp});
    endtask

    // Read register r on both ports of every variant.
    task automatic read_chk(input string tag, input logic [4:0] r,
                            input logic [63:0] e_byp, input logic [63:0] e_nob,
                            input logic [63:0] e_x64);
        rd_a = r;
        rd_b = r;
        #1;
        check({tag, "_byp_a"}, {32'd0, bus_byp.data_out_a}, e_byp);
        check({tag, "_byp_b"}, {32'd0, bus_byp.data_out_b}, e_byp);
        check({tag, "_nob_a"}, {32'd0, bus_nob.data_out_a}, e_nob);
        check({tag, "_nob_b"}, {32'd0, bus_nob.data_out_b}, e_nob);
        check({tag, "_x64_a"}, bus_x64.data_out_a, e_x64);
        check({tag, "_x64_b"}, bus_x64.data_out_b, e_x64);
    endtask

    task automatic all_zero(input string tag);
        for (int r = 0; r < 32; r++) begin
            read_chk(tag, 5'(r), 64'd0, 64'd0, 64'd0);
        end
    endtask

    // Driver: one write held across a single rising edge.
    task automatic do_write(input logic [4:0] addr, input logic [63:0] data,
                            input logic [2:0] p);
        @(negedge clk);
        we  = 1'b1;
        wa  = addr;
        wd  = data;
        pat = p;
        @(negedge clk);
        we  = 1'b0;
    endtask

    task automatic sweep_wait(input string tag);
        for (int k = 1; k <= 31; k++) begin
            @(negedge clk);
            #1;
            chk_ready(tag, k == 31);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n = 1'b0;
        rd_a = '0; rd_b = '0; wa = '0; we = 1'b0; clr = 1'b0;
        wd = '0; pat = 3'b010;

        repeat (3) @(negedge clk);
        rd_a = 5'd1;
        #1;
        chk_ready("rst_ready", 1'b0);
        check("rst_out_a", {32'd0, bus_byp.data_out_a}, 64'd0);
        check("rst_out_x64", bus_x64.data_out_a, 64'd0);
        rst_n = 1'b1;
        sweep_wait("rel_ready");
        all_zero("init_zero");

        // Formatting on x5
        do_write(5'd5, 64'h0000_00F0, 3'b000);
        read_chk("lb", 5'd5, 64'hFFFF_FFF0, 64'hFFFF_FFF0, 64'hFFFF_FFFF_FFFF_FFF0);
        do_write(5'd5, 64'h0000_00F0, 3'b100);
        read_chk("lbu", 5'd5, 64'h0000_00F0, 64'h0000_00F0, 64'h0000_00F0);
        do_write(5'd5, 64'h0000_8001, 3'b001);
        read_chk("lh", 5'd5, 64'hFFFF_8001, 64'hFFFF_8001, 64'hFFFF_FFFF_FFFF_8001);
        do_write(5'd5, 64'h0000_0055, 3'b111);
        read_chk("pat111", 5'd5, 64'hFFFF_8001, 64'hFFFF_8001, 64'hFFFF_FFFF_FFFF_8001);
        do_write(5'd5, 64'hA5A5_0000_0000_1234, 3'b011);
        read_chk("ld", 5'd5, 64'hFFFF_8001, 64'hFFFF_8001, 64'hA5A5_0000_0000_1234);
        do_write(5'd6, 64'h0000_7FFF, 3'b101);
        read_chk("lhu", 5'd6, 64'h0000_7FFF, 64'h0000_7FFF, 64'h0000_7FFF);

        // Same-cycle forwarding on x7
        @(negedge clk);
        rd_a = 5'd7; rd_b = 5'd0;
        we = 1'b1; wa = 5'd7; wd = 64'h1234_5678; pat = 3'b010;
        #1;
        check("byp_pre", {32'd0, bus_byp.data_out_a}, 64'h1234_5678);
        check("nob_pre", {32'd0, bus_nob.data_out_a}, 64'd0);
        check("x64_pre", bus_x64.data_out_a, 64'h1234_5678);
        check("byp_pre_b0", {32'd0, bus_byp.data_out_b}, 64'd0);
        @(negedge clk);
        we = 1'b0;
        read_chk("post_x7", 5'd7, 64'h1234_5678, 64'h1234_5678, 64'h1234_5678);

        // x0 never written, not even through the bypass path
        @(negedge clk);
        rd_a = 5'd0; rd_b = 5'd0;
        we = 1'b1; wa = 5'd0; wd = 64'hDEAD_BEEF; pat = 3'b010;
        #1;
        check("x0_pend", {32'd0, bus_byp.data_out_a}, 64'd0);
        @(negedge clk);
        we = 1'b0;
        read_chk("x0", 5'd0, 64'd0, 64'd0, 64'd0);

        // LWU/LW of 0x80000000 on x9
        do_write(5'd9, 64'h8000_0000, 3'b110);
        read_chk("lwu", 5'd9, 64'd0, 64'd0, 64'h0000_0000_8000_0000);
        do_write(5'd9, 64'h8000_0000, 3'b010);
        read_chk("lw_neg", 5'd9, 64'h8000_0000, 64'h8000_0000, 64'hFFFF_FFFF_8000_0000);

        // Clear with a simultaneous write to x3; writes held during the sweep
        do_write(5'd3, 64'h11, 3'b100);
        @(negedge clk);
        rd_a = 5'd3; rd_b = 5'd5;
        we = 1'b1; wa = 5'd3; wd = 64'hCAFE; pat = 3'b010; clr = 1'b1;
        #1;
        check("clr_pend_a", {32'd0, bus_byp.data_out_a}, 64'h11);
        @(negedge clk);
        clr = 1'b0;
        #1;
        chk_ready("clr_e0", 1'b0);
        check("clr_mask_b", {32'd0, bus_byp.data_out_b}, 64'd0);
        check("clr_mask_x64", bus_x64.data_out_b, 64'd0);
        for (int k = 1; k <= 31; k++) begin
            @(negedge clk);
            #1;
            chk_ready("clr_ready", k == 31);
        end
        we = 1'b0;
        all_zero("clr_zero");

        // Asynchronous reset while ready, then again mid-sweep
        @(negedge clk);
        rst_n = 1'b0;
        rd_a = 5'd0;
        #1;
        chk_ready("async_rst", 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            #1;
            chk_ready("mid_sweep", 1'b0);
        end
        rst_n = 1'b0;
        #1;
        chk_ready("mid_rst", 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        sweep_wait("restart");
        read_chk("after_restart", 5'd31, 64'd0, 64'd0, 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
